mant_mult_seq: RTL

Sequential mantissa-product and normalize stage of the single-precision FP multiplier, directly upstream of the rounding stage. Accepts two IEEE-754 binary32 operands over a valid/ready handshake, computes the 24x24 mantissa product with an iterative shift-add datapath, and normalizes it. Presents the 24-bit mantissa, guard bit, sticky bit, sign, unrounded exponent and special-case flags that the rounder consumes.

---
 rtl/mant_mult_pkg.sv | 36 +++
 rtl/mant_mult_seq_normalize.sv | 28 ++
 rtl/mant_mult_seq.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mant_mult_pkg.sv
// Shared constants, FSM state and result bundle for the sequential mantissa multiplier.
// MANT_MULT_RADIX4_EN selects two multiplier bits per MUL cycle instead of one.
package mant_mult_pkg;

  localparam int MANT_W   = 24;
  localparam int EXP_W    = 10;
  localparam int EXP_BIAS = 127;
  localparam int PROD_W   = 2 * MANT_W;

`ifdef MANT_MULT_RADIX4_EN
  localparam int STEP_BITS = 2;
`else
  localparam int STEP_BITS = 1;
`endif
  localparam int MUL_STEPS = MANT_W / STEP_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } mult_state_t;

  // Everything the rounder consumes, in one bundle.
  typedef struct packed {
    logic [MANT_W-1:0] mantissa;
    logic              guard;
    logic              sticky;
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic              is_zero;
    logic              is_inf;
    logic              is_nan;
  } mult_result_t;

endpackage

// File: rtl/mant_mult_seq_normalize.sv
// Combinational normalize of the 48-bit mantissa product into mantissa/guard/sticky
// with the matching exponent adjustment.
module mant_normalize
  import mant_mult_pkg::*;
(
  input  logic [PROD_W-1:0] prod,
  input  logic [EXP_W-1:0]  exp_in,
  output logic [MANT_W-1:0] mantissa,
  output logic              guard,
  output logic              sticky,
  output logic [EXP_W-1:0]  exp_adj
);

  // Product of two [1,2) mantissas lies in [1,4): only a one-position choice.
  always_comb begin
    mantissa = prod[PROD_W-2:MANT_W-1];
    guard    = prod[MANT_W-2];
    sticky   = |prod[MANT_W-3:0];
    exp_adj  = exp_in;
    if (prod[PROD_W-1]) begin
      mantissa = prod[PROD_W-1:MANT_W];
      guard    = prod[MANT_W-1];
      sticky   = |prod[MANT_W-2:0];
      exp_adj  = exp_in + 10'd1;
    end
  end

endmodule

// File: rtl/mant_mult_seq.sv
// Sequential shift-add mantissa multiplier and normalize stage feeding the FP rounder.
// Build option: MANT_MULT_RADIX4_EN (radix-4 steps, 12 MUL cycles instead of 24).
module mant_mult_seq
  import mant_mult_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       a,
  input  logic [31:0]       b,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] mantissa_out,
  output logic              guard_bit,
  output logic              sticky_bit,
  output logic              sign_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic              is_zero,
  output logic              is_inf,
  output logic              is_nan,
  output mult_state_t       state_dbg
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // out_valid and the result stay put until that edge, in_ready is high only in IDLE.

  localparam logic [4:0] LAST_STEP = 5'(MUL_STEPS - 1);

  mult_state_t       state_q, state_d;
  logic [PROD_W-1:0] acc_q, ma_q, addend;
  logic [MANT_W-1:0] mb_q;
  logic [4:0]        cnt_q;
  logic              sign_q, zero_q, inf_q, nan_q;
  logic [EXP_W-1:0]  exp_sum_q;
  mult_result_t      res_q, res_d;
  logic              out_valid_q;

  logic [7:0] ea, eb;
  logic       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic       sp_nan, sp_inf, sp_zero;

  logic [MANT_W-1:0] norm_mant;
  logic              norm_guard, norm_sticky;
  logic [EXP_W-1:0]  norm_exp;

  assign ea     = a[30:23];
  assign eb     = b[30:23];
  // Subnormals count as zero.
  assign a_zero = (ea == 8'd0);
  assign b_zero = (eb == 8'd0);
  assign a_inf  = (ea == 8'hFF) && (a[22:0] == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (b[22:0] == 23'd0);
  assign a_nan  = (ea == 8'hFF) && (a[22:0] != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (b[22:0] != 23'd0);
  assign sp_nan  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
  assign sp_inf  = ~sp_nan & (a_inf | b_inf);
  assign sp_zero = ~sp_nan & ~sp_inf & (a_zero | b_zero);

`ifdef MANT_MULT_RADIX4_EN
  assign addend = (mb_q[0] ? ma_q : '0) + (mb_q[1] ? (ma_q << 1) : '0);
`else
  assign addend = mb_q[0] ? ma_q : '0;
`endif

  mant_normalize u_norm (
    .prod     (acc_q),
    .exp_in   (exp_sum_q),
    .mantissa (norm_mant),
    .guard    (norm_guard),
    .sticky   (norm_sticky),
    .exp_adj  (norm_exp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = MUL;
      MUL:     if (cnt_q == LAST_STEP) state_d = NORM;
      NORM:    state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    res_d          = '0;
    res_d.sign     = sign_q;
    res_d.is_zero  = zero_q;
    res_d.is_inf   = inf_q;
    res_d.is_nan   = nan_q;
    if (!(zero_q | inf_q | nan_q)) begin
      res_d.mantissa = norm_mant;
      res_d.guard    = norm_guard;
      res_d.sticky   = norm_sticky;
      res_d.exp      = norm_exp;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      ma_q        <= '0;
      mb_q        <= '0;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      zero_q      <= 1'b0;
      inf_q       <= 1'b0;
      nan_q       <= 1'b0;
      exp_sum_q   <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (in_valid) begin
          acc_q     <= '0;
          cnt_q     <= '0;
          ma_q      <= {{MANT_W{1'b0}}, ~a_zero, a[22:0]};
          mb_q      <= {~b_zero, b[22:0]};
          sign_q    <= a[31] ^ b[31];
          exp_sum_q <= {2'b00, ea} + {2'b00, eb} - 10'(EXP_BIAS);
          zero_q    <= sp_zero;
          inf_q     <= sp_inf;
          nan_q     <= sp_nan;
        end
        MUL: begin
          acc_q <= acc_q + addend;
          ma_q  <= ma_q << STEP_BITS;
          mb_q  <= mb_q >> STEP_BITS;
          cnt_q <= cnt_q + 5'd1;
        end
        NORM: begin
          res_q       <= res_d;
          out_valid_q <= 1'b1;
        end
        DONE: if (out_ready) out_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign in_ready     = (state_q == IDLE) && !rst;
  assign out_valid    = out_valid_q;
  assign mantissa_out = res_q.mantissa;
  assign guard_bit    = res_q.guard;
  assign sticky_bit   = res_q.sticky;
  assign sign_out     = res_q.sign;
  assign exp_out      = res_q.exp;
  assign is_zero      = res_q.is_zero;
  assign is_inf       = res_q.is_inf;
  assign is_nan       = res_q.is_nan;
  assign state_dbg    = state_q;

endmodule
